als_spi_reader: RTL and testbench



---
 rtl/als_spi_reader_if.sv | 18 +
 rtl/als_spi_reader.sv | 171 +++++++++++++++++
 tb/tb_als_spi_reader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/als_spi_reader_if.sv
//------------------------------------------------------------------------------
// Module      : als_spi_reader_if
// Description : SPI bus between the receive master and the serial device.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface als_spi_reader_if;
  logic cs_n;
  logic sck;
  logic sdo;

  modport master (output cs_n, output sck, input sdo);
  modport slave  (input cs_n, input sck, output sdo);
endinterface

`default_nettype wire

// File: rtl/als_spi_reader.sv
//------------------------------------------------------------------------------
// Module      : als_spi_reader
// Description : SPI mode-3 receive master; divided SCK, framed by CS, extracts
//               a data window per frame, single-shot or continuous.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module als_spi_reader #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 3,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  als_spi_reader_if.master  spi,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int c_CNT_MAX    = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int c_CNT_W      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
  localparam int c_BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int c_GAP_LAST_I = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

  localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(c_GAP_LAST_I);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(FRAME_BITS - 1);
  localparam logic [c_BIT_W:0]   c_WIN_LO   = (c_BIT_W + 1)'(LEAD_BITS);
  localparam logic [c_BIT_W:0]   c_WIN_N    = (c_BIT_W + 1)'(DATA_W);

  logic [2:0]         r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [c_BIT_W-1:0] r_bit, w_bit_nxt;
  logic               r_half, w_half_nxt;
  logic               w_shift_en;
  logic [DATA_W-1:0]  r_shreg, w_shreg_shifted;
  logic [DATA_W-1:0]  r_data;
  logic               r_cs_n, r_sck, r_valid, r_busy;
  logic               w_cs_n_nxt, w_sck_nxt, w_valid_nxt, w_busy_nxt, w_load;
  logic [c_BIT_W:0]   w_win_off;
  logic               w_in_win;

  // Offset is one bit wider so bits before the window wrap to a large value.
  assign w_win_off = {1'b0, r_bit} - c_WIN_LO;
  assign w_in_win  = (w_win_off < c_WIN_N);

  generate
    if (DATA_W == 1) begin : g_shift_1
      assign w_shreg_shifted = spi.sdo;
    end else if (MSB_FIRST != 0) begin : g_shift_msb
      assign w_shreg_shifted = {r_shreg[DATA_W-2:0], spi.sdo};
    end else begin : g_shift_lsb
      assign w_shreg_shifted = {spi.sdo, r_shreg[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_half  <= 1'b0;
      r_shreg <= '0;
      r_data  <= '0;
      r_cs_n  <= 1'b1;
      r_sck   <= 1'b1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_half  <= w_half_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_sck   <= w_sck_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      if (w_shift_en) r_shreg <= w_shreg_shifted;
      if (w_load)     r_data  <= r_shreg;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_half_nxt  = r_half;
    w_shift_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || continuous) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
        end
      end
      S_SETUP: begin
        if (r_cnt == c_DIV_LAST) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_half_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_cnt == c_DIV_LAST) begin
          w_cnt_nxt = '0;
          if (!r_half) begin
            // This edge raises sck, so sdo is sampled here.
            w_half_nxt = 1'b1;
            w_shift_en = w_in_win;
          end else if (r_bit == c_BIT_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_half_nxt = 1'b0;
            w_bit_nxt  = r_bit + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_cnt_nxt = '0;
        if (GAP_CYCLES > 1) w_state_nxt = S_GAP;
        else                w_state_nxt = continuous ? S_SETUP : S_IDLE;
      end
      S_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = continuous ? S_SETUP : S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    w_cs_n_nxt  = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT));
    w_sck_nxt   = !((w_state_nxt == S_SHIFT) && !w_half_nxt);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_valid_nxt = (w_state_nxt == S_DONE);
    w_load      = (w_state_nxt == S_DONE);
  end

  assign spi.cs_n   = r_cs_n;
  assign spi.sck    = r_sck;
  assign data       = r_data;
  assign data_valid = r_valid;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_als_spi_reader.sv
//------------------------------------------------------------------------------
// Module      : tb_als_spi_reader
// Description : Directed bench for als_spi_reader (MSB-first and LSB-first).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_als_spi_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       continuous;
  logic       sdo_drv = 1'b0;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b;

  als_spi_reader_if bus_a ();
  als_spi_reader_if bus_b ();
  assign bus_a.sdo = sdo_drv;
  assign bus_b.sdo = sdo_drv;

  als_spi_reader #(.CLK_DIV(2), .FRAME_BITS(16), .LEAD_BITS(3), .DATA_W(8),
                   .GAP_CYCLES(4), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .spi(bus_a.master), .data(data_a), .data_valid(valid_a), .busy(busy_a));

  als_spi_reader #(.CLK_DIV(2), .FRAME_BITS(16), .LEAD_BITS(3), .DATA_W(8),
                   .GAP_CYCLES(4), .MSB_FIRST(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .spi(bus_b.master), .data(data_b), .data_valid(valid_b), .busy(busy_b));

  always #5 clk = ~clk;

  // Device model: frame latched at cs_n fall, one bit driven per sck fall.
  logic [15:0] dev_default = 16'h1660;
  logic [15:0] dev_frame   = 16'h0;
  logic [15:0] dev_q[$];
  int          dev_idx     = 0;

  always @(negedge bus_a.cs_n) begin
    dev_idx = 0;
    if (dev_q.size() > 0) dev_frame = dev_q.pop_front();
    else                  dev_frame = dev_default;
  end

  always @(negedge bus_a.sck) begin
    if (!bus_a.cs_n && dev_idx < 16) begin
      sdo_drv = dev_frame[15 - dev_idx];
      dev_idx = dev_idx + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Statistics gathered by observe()
  int         n_cs_fall, n_cs_low, n_sck_rise, n_valid, n_glitch;
  int         rise_cyc, valid_cyc, last_busy_cyc, high_run, gap_len, busy_low_mid;
  bit         busy_seen, idle_done;
  logic [7:0] vdata_a[$];
  logic [7:0] last_b;

  task automatic observe(input int max_cyc, input bit stop_idle, input int drop_fall,
                         input int repulse_cyc, input int stop_sck);
    logic prev_cs, prev_sck;
    logic [7:0] prev_data;
    n_cs_fall = 0; n_cs_low = 0; n_sck_rise = 0; n_valid = 0; n_glitch = 0;
    rise_cyc = -1; valid_cyc = -1; last_busy_cyc = -1; high_run = 0; gap_len = -1;
    busy_low_mid = 0; busy_seen = 0; idle_done = 0; vdata_a.delete(); last_b = 8'h0;
    prev_cs = bus_a.cs_n; prev_sck = bus_a.sck; prev_data = data_a;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == repulse_cyc) start = 1'b1;
      else if (c == repulse_cyc + 1) start = 1'b0;
      if (prev_cs && !bus_a.cs_n) begin
        if (n_cs_fall > 0) gap_len = high_run;
        high_run = 0;
        n_cs_fall++;
      end
      if (!bus_a.cs_n) n_cs_low++;
      else if (n_cs_fall > 0) high_run++;
      if (!prev_cs && bus_a.cs_n) rise_cyc = c;
      if (!prev_sck && bus_a.sck) n_sck_rise++;
      if (valid_a) begin
        n_valid++; valid_cyc = c; vdata_a.push_back(data_a); last_b = data_b;
      end else if (data_a !== prev_data) begin
        n_glitch++;
      end
      if (busy_a) begin busy_seen = 1; last_busy_cyc = c; end
      else if (n_cs_fall > 0 && n_valid < 2 && drop_fall >= 0) busy_low_mid++;
      if (drop_fall >= 0 && n_cs_fall == drop_fall && !bus_a.cs_n) continuous = 1'b0;
      prev_cs = bus_a.cs_n; prev_sck = bus_a.sck; prev_data = data_a;
      if (stop_sck > 0 && n_sck_rise == stop_sck) break;
      if (stop_idle && busy_seen && !busy_a) begin idle_done = 1; break; end
    end
    if (stop_idle) chk("observe_timeout", {31'd0, idle_done}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  exp_msb;
    logic [7:0]  exp_lsb;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h1660, 8'hB3, 8'hCD};
    vecs[1] = '{16'h0240, 8'h12, 8'h48};
    vecs[2] = '{16'h1FC0, 8'hFE, 8'h7F};
    vecs[3] = '{16'hE01F, 8'h00, 8'h00};
    vecs[4] = '{16'hFFFF, 8'hFF, 8'hFF};
    vecs[5] = '{16'h0AA0, 8'h55, 8'hAA};

    rst_n = 1'b0; start = 1'b0; continuous = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n",  {31'd0, bus_a.cs_n}, 32'd1);
    chk("rst_sck",   {31'd0, bus_a.sck},  32'd1);
    chk("rst_data",  {24'd0, data_a},     32'd0);
    chk("rst_valid", {31'd0, valid_a},    32'd0);
    chk("rst_busy",  {31'd0, busy_a},     32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cs_n", {31'd0, bus_a.cs_n}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      dev_default = vecs[i].frame;
      pulse_start();
      observe(400, 1'b1, -1, -1, 0);
      chk("cs_low_cycles", n_cs_low,   66);
      chk("sck_rises",     n_sck_rise, 16);
      chk("valid_pulses",  n_valid,    1);
      chk("data_msb",      {24'd0, data_a}, {24'd0, vecs[i].exp_msb});
      chk("data_lsb",      {24'd0, last_b}, {24'd0, vecs[i].exp_lsb});
      chk("valid_at_cs_rise", valid_cyc, rise_cyc);
      chk("busy_tail",     last_busy_cyc - valid_cyc + 1, 4);
      chk("data_stable",   n_glitch, 0);
    end

    // Continuous: two frames back to back, continuous dropped in the second.
    dev_q.push_back(16'h0240);
    dev_q.push_back(16'h1FC0);
    @(negedge clk);
    continuous = 1'b1;
    observe(600, 1'b1, 2, -1, 0);
    chk("cont_valid_pulses", n_valid, 2);
    chk("cont_frames",       n_cs_fall, 2);
    if (vdata_a.size() == 2) begin
      chk("cont_data0", {24'd0, vdata_a[0]}, 32'h12);
      chk("cont_data1", {24'd0, vdata_a[1]}, 32'hFE);
    end else begin
      chk("cont_data_count", vdata_a.size(), 2);
    end
    chk("cont_gap_cycles", gap_len, 4);
    chk("cont_busy_held",  busy_low_mid, 0);
    observe(150, 1'b0, -1, -1, 0);
    chk("cont_no_third_frame", n_cs_fall, 0);
    chk("cont_idle_busy", {31'd0, busy_a}, 32'd0);

    // start re-pulsed during SHIFT is ignored.
    dev_default = 16'h1660;
    pulse_start();
    observe(300, 1'b0, -1, 20, 0);
    chk("repulse_frames", n_cs_fall, 1);
    chk("repulse_valid",  n_valid,   1);
    chk("repulse_data",   {24'd0, data_a}, 32'hB3);

    // Reset asserted at sck rising edge 7 of a frame.
    dev_default = 16'h0240;
    pulse_start();
    observe(200, 1'b0, -1, -1, 7);
    chk("pre_rst_sck_edges", n_sck_rise, 7);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_n",  {31'd0, bus_a.cs_n}, 32'd1);
    chk("midrst_sck",   {31'd0, bus_a.sck},  32'd1);
    chk("midrst_data",  {24'd0, data_a},     32'd0);
    chk("midrst_valid", {31'd0, valid_a},    32'd0);
    chk("midrst_busy",  {31'd0, busy_a},     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dev_default = 16'h1660;
    pulse_start();
    observe(400, 1'b1, -1, -1, 0);
    chk("post_rst_cs_low", n_cs_low,   66);
    chk("post_rst_sck",    n_sck_rise, 16);
    chk("post_rst_data",   {24'd0, data_a}, 32'hB3);
    chk("post_rst_valid",  n_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
